// File: rtl/vdp_video_pkg.sv
// Shared video definitions for the VDP HDMI output path:
// mode-switch FSM states, VIC codes and frame geometry.
package vdp_video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_HOLD_RESET,
    ST_SETTLE
  } sw_state_e;

  localparam logic [6:0] VIC_NTSC = 7'd2;
  localparam logic [6:0] VIC_PAL  = 7'd17;

  localparam int H_TOTAL_NTSC = 858;
  localparam int V_TOTAL_NTSC = 525;
  localparam int H_TOTAL_PAL  = 864;
  localparam int V_TOTAL_PAL  = 625;

  // Counter width for a count of n, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [6:0] vic_for(input logic pal);
    return pal ? VIC_PAL : VIC_NTSC;
  endfunction

  function automatic int frame_cycles(input logic pal);
    return pal ? H_TOTAL_PAL * V_TOTAL_PAL
               : H_TOTAL_NTSC * V_TOTAL_NTSC;
  endfunction

endpackage

// File: rtl/frame_tick_detect.sv
// Frame boundary detector: one-cycle tick when cx/cy
// first reaches 0/0; a held origin counts only once.
module frame_tick_detect
  import vdp_video_pkg::*;
#(
  parameter int CXW = 12,
  parameter int CYW = 11
) (
  input  logic           clk_pixel,
  input  logic           reset,
  input  logic [CXW-1:0] cx_i,
  input  logic [CYW-1:0] cy_i,
  output logic           tick_o
);

  logic at_origin;
  logic at_origin_q;

  assign at_origin = (cx_i == '0) && (cy_i == '0);

  // Remember last cycle's origin flag for edge detection.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      at_origin_q <= 1'b0;
    end else begin
      at_origin_q <= at_origin;
    end
  end

  assign tick_o = at_origin & ~at_origin_q;

endmodule

// File: rtl/hdmi_mode_switch_sequencer.sv
// NTSC/PAL switch sequencer for the HDMI output stage.
// Define HDMI_MODE_SWITCH_AUDIO_MUTE_EN to mute audio across a switch.
module hdmi_mode_switch_sequencer
  import vdp_video_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int SETTLE_FRAMES = 2,
  parameter int FRAME_TIMEOUT = 1000000
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        pal_mode_req,
  input  logic        include_audio_req,
  input  logic [11:0] cx,
  input  logic [10:0] cy,
  output logic        pal_mode,
  output logic        hdmi_reset,
  output logic        include_audio,
  output logic        busy,
  output logic        switch_done
);

  localparam int TW = cnt_w(FRAME_TIMEOUT);
  localparam int RW = cnt_w(RESET_CYCLES);
  localparam int FW = cnt_w(SETTLE_FRAMES);

  localparam logic [TW-1:0] TO_LAST = TW'(FRAME_TIMEOUT - 1);
  localparam logic [RW-1:0] RC_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [FW-1:0] SF_LAST = FW'(SETTLE_FRAMES - 1);

  localparam logic [TW-1:0] TO_MAX = '1;
  localparam logic [RW-1:0] RC_MAX = '1;
  localparam logic [FW-1:0] SF_MAX = '1;

  sw_state_e     state_q;
  logic          pal_q;
  logic          hrst_q;
  logic          aud_q;
  logic          busy_q;
  logic          done_q;
  logic          first_q;
  logic [TW-1:0] to_cnt_q;
  logic [RW-1:0] rst_cnt_q;
  logic [FW-1:0] frm_cnt_q;
  logic          tick;

  frame_tick_detect #(
    .CXW(12),
    .CYW(11)
  ) u_tick (
    .clk_pixel(clk_pixel),
    .reset    (reset),
    .cx_i     (cx),
    .cy_i     (cy),
    .tick_o   (tick)
  );

  // Switch FSM; every output is a register set on the transition.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q   <= ST_HOLD_RESET;
      pal_q     <= 1'b0;
      hrst_q    <= 1'b1;
      aud_q     <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      first_q   <= 1'b1;
      to_cnt_q  <= '0;
      rst_cnt_q <= '0;
      frm_cnt_q <= '0;
    end else begin
      done_q  <= 1'b0;
      first_q <= 1'b0;
      // Power-up adopts the request directly, then settles.
      if (first_q) begin
        pal_q <= pal_mode_req;
      end
      case (state_q)
        ST_IDLE: begin
          if (pal_mode_req != pal_q) begin
            state_q  <= ST_WAIT_FRAME;
            busy_q   <= 1'b1;
            to_cnt_q <= '0;
          end
        end
        ST_WAIT_FRAME: begin
          if (pal_mode_req == pal_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (tick || (to_cnt_q == TO_LAST)) begin
            state_q   <= ST_HOLD_RESET;
            hrst_q    <= 1'b1;
            pal_q     <= pal_mode_req;
            rst_cnt_q <= '0;
          end else if (to_cnt_q != TO_MAX) begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        ST_HOLD_RESET: begin
          if (rst_cnt_q == RC_LAST) begin
            state_q   <= ST_SETTLE;
            hrst_q    <= 1'b0;
            frm_cnt_q <= '0;
          end else if (rst_cnt_q != RC_MAX) begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (tick) begin
            if (frm_cnt_q == SF_LAST) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (frm_cnt_q != SF_MAX) begin
              frm_cnt_q <= frm_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q   <= ST_HOLD_RESET;
          hrst_q    <= 1'b1;
          busy_q    <= 1'b1;
          rst_cnt_q <= '0;
        end
      endcase
`ifdef HDMI_MODE_SWITCH_AUDIO_MUTE_EN
      aud_q <= include_audio_req & (state_q == ST_IDLE);
`else
      aud_q <= include_audio_req;
`endif
    end
  end

  assign pal_mode      = pal_q;
  assign hdmi_reset    = hrst_q;
  assign include_audio = aud_q;
  assign busy          = busy_q;
  assign switch_done   = done_q;

endmodule

// File: tb/tb_hdmi_mode_switch_sequencer.sv
// Bench for hdmi_mode_switch_sequencer: directed table,
// hand sequences and random stimulus against a reference model.
module tb_hdmi_mode_switch_sequencer;

  localparam int RC   = 4;
  localparam int SF   = 1;
  localparam int FT   = 100;
  localparam int LINE = 50;

  localparam int P_IDLE   = 0;
  localparam int P_WAIT   = 1;
  localparam int P_HOLD   = 2;
  localparam int P_SETTLE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        areq;
  logic [11:0] cx;
  logic [10:0] cy;
  logic        pal;
  logic        hrst;
  logic        aud;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int ph;
  int m_left;
  bit m_pal;
  bit m_aud;
  bit m_done;
  bit m_first;
  bit m_prev_org;

  // cx/cy stimulus model
  int pos;
  bit frz;

  typedef struct {
    bit req;
    bit areq;
    bit frz;
    int cycles;
    bit e_pal;
    bit e_hrst;
    bit e_busy;
  } vec_t;

  vec_t vecs[9];

  hdmi_mode_switch_sequencer #(
    .RESET_CYCLES (RC),
    .SETTLE_FRAMES(SF),
    .FRAME_TIMEOUT(FT)
  ) dut (
    .clk_pixel        (clk),
    .reset            (rst),
    .pal_mode_req     (req),
    .include_audio_req(areq),
    .cx               (cx),
    .cy               (cy),
    .pal_mode         (pal),
    .hdmi_reset       (hrst),
    .include_audio    (aud),
    .busy             (busy),
    .switch_done      (done)
  );

  always #5 clk = ~clk;

  task automatic check1(string nm, logic a, logic e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t",
               nm, a, e, $time);
    end
  endtask

  task automatic check_int(string nm, int a, int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, a, e, $time);
    end
  endtask

  // One clock edge of the specified behaviour, using the
  // inputs that were present before the edge.
  task automatic model_edge();
    bit org;
    bit tk;
    if (rst) begin
      ph         = P_HOLD;
      m_left     = RC;
      m_pal      = 1'b0;
      m_aud      = 1'b0;
      m_done     = 1'b0;
      m_first    = 1'b1;
      m_prev_org = 1'b0;
      return;
    end
    org        = (cx == 0) && (cy == 0);
    tk         = org && !m_prev_org;
    m_prev_org = org;
    m_done     = 1'b0;
`ifdef HDMI_MODE_SWITCH_AUDIO_MUTE_EN
    m_aud = areq && (ph == P_IDLE);
`else
    m_aud = areq;
`endif
    if (m_first) begin
      m_pal   = req;
      m_first = 1'b0;
    end
    case (ph)
      P_IDLE: begin
        if (req != m_pal) begin
          ph     = P_WAIT;
          m_left = FT;
        end
      end
      P_WAIT: begin
        if (req == m_pal) begin
          ph = P_IDLE;
        end else if (tk || m_left == 1) begin
          ph     = P_HOLD;
          m_left = RC;
          m_pal  = req;
        end else begin
          m_left--;
        end
      end
      P_HOLD: begin
        m_left--;
        if (m_left == 0) begin
          ph     = P_SETTLE;
          m_left = SF;
        end
      end
      P_SETTLE: begin
        if (tk) begin
          m_left--;
          if (m_left == 0) begin
            ph     = P_IDLE;
            m_done = 1'b1;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic drive_xy();
    if (ph == P_HOLD) begin
      cx = '0;
      cy = '0;
    end else if (frz) begin
      cx = 12'd7;
      cy = 11'd3;
    end else begin
      cx = 12'(pos);
      cy = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check1("pal_mode", pal, m_pal);
    check1("hdmi_reset", hrst, ph == P_HOLD);
    check1("busy", busy, ph != P_IDLE);
    check1("switch_done", done, m_done);
    check1("include_audio", aud, m_aud);
    if (ph == P_HOLD) pos = 0;
    else pos = (pos + 1) % LINE;
    drive_xy();
  endtask

  initial begin
    int k;
    int nd;
    bit seen;

    vecs[0] = '{1, 1, 0,  10, 1, 0, 0};
    vecs[1] = '{0, 1, 0, 200, 0, 0, 0};
    vecs[2] = '{0, 1, 1,  20, 0, 0, 0};
    vecs[3] = '{1, 1, 1,  50, 0, 0, 1};
    vecs[4] = '{1, 1, 1,  51, 1, 1, 1};
    vecs[5] = '{1, 1, 0, 200, 1, 0, 0};
    vecs[6] = '{0, 1, 1,  10, 1, 0, 1};
    vecs[7] = '{1, 1, 1,   3, 1, 0, 0};
    vecs[8] = '{1, 1, 0,  20, 1, 0, 0};

    rst  = 1'b1;
    req  = 1'b1;
    areq = 1'b1;
    frz  = 1'b0;
    pos  = 0;
    ph   = P_HOLD;
    drive_xy();

    // Power-up: reset held 3 cycles
    repeat (3) step();
    rst = 1'b0;
    step();
    check1("pu_pal_after_release", pal, 1'b1);
    k = 1;
    while (hrst && k < 10) begin
      step();
      k++;
    end
    check_int("pu_hrst_cycles", k, RC);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    check1("pu_switch_done", seen, 1'b1);
    step();
    check1("pu_busy_low", busy, 1'b0);

    // Directed table
    foreach (vecs[i]) begin
      req  = vecs[i].req;
      areq = vecs[i].areq;
      frz  = vecs[i].frz;
      drive_xy();
      repeat (vecs[i].cycles) step();
      check1($sformatf("vec%0d_pal", i), pal, vecs[i].e_pal);
      check1($sformatf("vec%0d_hrst", i), hrst, vecs[i].e_hrst);
      check1($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
    end

    // Toggle back during SETTLE: two complete switches
    req = 1'b0;
    nd  = 0;
    k   = 0;
    while (!hrst && k < 100) begin
      step();
      if (done) nd++;
      k++;
    end
    check1("tog_hrst_seen", hrst, 1'b1);
    k = 0;
    while (hrst && k < 20) begin
      step();
      if (done) nd++;
      k++;
    end
    req = 1'b1;
    repeat (300) begin
      step();
      if (done) nd++;
    end
    check_int("tog_done_count", nd, 2);
    check1("tog_final_pal", pal, 1'b1);
    check1("tog_final_busy", busy, 1'b0);

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) req = ~req;
      if ($urandom_range(0, 19) == 0) areq = 1'($urandom);
      if ($urandom_range(0, 199) == 0) frz = ~frz;
      rst = ($urandom_range(0, 799) == 0);
      drive_xy();
      step();
    end
    rst = 1'b0;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
